sd_cmd_responder: RTL

//  Card-side endpoint of the SD CMD line: the counterpart of the host command engine.

---
 rtl/sd_cmd_responder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit host commands (CRC7 checked),
// hands index/argument to card logic and serialises the R1/R2/R3 response it returns.
module sd_cmd_responder #(
   parameter int NCR         = 2,
   parameter int RSP_TIMEOUT = 64
) (
   input  logic         sdClk,
   input  logic         sysRst,
   input  logic         sdCmdIn,
   output logic         sdCmdOut,
   output logic         sdCmdEn,
   output logic         cmdValid,
   output logic [5:0]   cmdIndex,
   output logic [31:0]  cmdArg,
   output logic         crcErr,
   input  logic         rspValid,
   input  logic [1:0]   rspType,
   input  logic [119:0] rspData,
   output logic         rspBusy,
   output logic         rspDone
);

   typedef enum logic [2:0] {S_IDLE, S_RX, S_CHECK, S_WAIT, S_TX} state_t;

   localparam logic [6:0] NCR_C = 7'(NCR);
   localparam logic [6:0] TO_C  = 7'(RSP_TIMEOUT);

   state_t         state_q;
   logic [5:0]     rxCnt_q;
   logic [44:0]    rxSh_q;
   logic [6:0]     rxCrc_q, rxCrc_d;
   logic [6:0]     wCnt_q, wCnt_d;
   logic           cap_q;
   logic [1:0]     capType_q;
   logic [119:0]   capData_q;
   logic [127:0]   txSh_q;
   logic [7:0]     txCnt_q, txLen_q;
   logic           txR2_q, txR3_q;
   logic [6:0]     txCrc_q, txCrc_d;
   logic           sdCmdOut_q, sdCmdEn_q, cmdValid_q, crcErr_q, rspBusy_q, rspDone_q;
   logic [5:0]     cmdIndex_q;
   logic [31:0]    cmdArg_q;

   logic           rspGot;
   logic [1:0]     selType;
   logic [119:0]   selData;
   logic [126:0]   txBody;

   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = c[6] ^ b;
      return {c[5:3], c[2] ^ fb, c[1:0], fb};
   endfunction

   always_comb begin
      rspGot  = cap_q | rspValid;
      selType = cap_q ? capType_q : rspType;
      selData = cap_q ? capData_q : rspData;
      wCnt_d  = (wCnt_q == 7'h7F) ? wCnt_q : wCnt_q + 7'd1;
      rxCrc_d = crc7_step(rxCrc_q, sdCmdIn);
      txCrc_d = crc7_step(txCrc_q, txSh_q[127]);
      // Frame bits after the start bit; short frames are left-aligned and zero padded.
      unique case (selType)
         2'd2:    txBody = {1'b0, 6'h3F, selData};
         2'd3:    txBody = {1'b0, 6'h3F, selData[31:0], 88'd0};
         default: txBody = {1'b0, selData[37:32], selData[31:0], 88'd0};
      endcase
   end

   always_ff @(posedge sdClk) begin
      if (sysRst) begin
         state_q    <= S_IDLE;
         rxCnt_q    <= '0;
         rxSh_q     <= '0;
         rxCrc_q    <= '0;
         wCnt_q     <= '0;
         cap_q      <= 1'b0;
         capType_q  <= '0;
         capData_q  <= '0;
         txSh_q     <= '0;
         txCnt_q    <= '0;
         txLen_q    <= '0;
         txR2_q     <= 1'b0;
         txR3_q     <= 1'b0;
         txCrc_q    <= '0;
         sdCmdOut_q <= 1'b1;
         sdCmdEn_q  <= 1'b0;
         cmdValid_q <= 1'b0;
         crcErr_q   <= 1'b0;
         rspBusy_q  <= 1'b0;
         rspDone_q  <= 1'b0;
         cmdIndex_q <= '0;
         cmdArg_q   <= '0;
      end else begin
         cmdValid_q <= 1'b0;
         crcErr_q   <= 1'b0;
         rspDone_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (!sdCmdIn) begin
                  state_q <= S_RX;
                  rxCnt_q <= 6'd1;
                  rxCrc_q <= '0;
               end
            end
            S_RX: begin
               rxCnt_q <= rxCnt_q + 6'd1;
               if (rxCnt_q == 6'd1 && !sdCmdIn) begin
                  state_q <= S_IDLE;
               end else if (rxCnt_q == 6'd47) begin
                  state_q <= S_CHECK;
                  wCnt_q  <= '0;
                  cap_q   <= 1'b0;
                  if (sdCmdIn && rxCrc_q == rxSh_q[6:0]) begin
                     cmdValid_q <= 1'b1;
                     cmdIndex_q <= rxSh_q[44:39];
                     cmdArg_q   <= rxSh_q[38:7];
                  end else begin
                     crcErr_q <= 1'b1;
                  end
               end else begin
                  rxSh_q <= {rxSh_q[43:0], sdCmdIn};
                  if (rxCnt_q < 6'd40) rxCrc_q <= rxCrc_d;
               end
            end
            S_CHECK: begin
               wCnt_q  <= wCnt_d;
               state_q <= cmdValid_q ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
               wCnt_q <= wCnt_d;
               if (!cap_q && rspValid) begin
                  cap_q     <= 1'b1;
                  capType_q <= rspType;
                  capData_q <= rspData;
               end
               if (rspGot && selType == 2'd0) begin
                  state_q <= S_IDLE;
               end else if (rspGot && wCnt_q >= NCR_C) begin
                  state_q    <= S_TX;
                  sdCmdEn_q  <= 1'b1;
                  sdCmdOut_q <= 1'b0;
                  rspBusy_q  <= 1'b1;
                  txSh_q     <= {txBody, 1'b0};
                  txCnt_q    <= 8'd1;
                  txCrc_q    <= '0;
                  txR2_q     <= (selType == 2'd2);
                  txR3_q     <= (selType == 2'd3);
                  txLen_q    <= (selType == 2'd2) ? 8'd128 : 8'd40;
               end else if (!rspGot && wCnt_q >= TO_C - 7'd1) begin
                  state_q <= S_IDLE;
               end
            end
            S_TX: begin
               txCnt_q <= txCnt_q + 8'd1;
               if (txCnt_q < txLen_q) begin
                  sdCmdOut_q <= txSh_q[127];
                  txSh_q     <= {txSh_q[126:0], 1'b0};
                  // R2 CRC covers only the 120 payload bits, not the header byte.
                  if (!txR2_q || txCnt_q >= 8'd8) txCrc_q <= txCrc_d;
               end else if (txCnt_q < txLen_q + 8'd7) begin
                  sdCmdOut_q <= txR3_q | txCrc_q[6];
                  txCrc_q    <= {txCrc_q[5:0], 1'b0};
               end else if (txCnt_q == txLen_q + 8'd7) begin
                  sdCmdOut_q <= 1'b1;
               end else begin
                  sdCmdEn_q  <= 1'b0;
                  sdCmdOut_q <= 1'b1;
                  rspBusy_q  <= 1'b0;
                  rspDone_q  <= 1'b1;
                  state_q    <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign sdCmdOut = sdCmdOut_q;
   assign sdCmdEn  = sdCmdEn_q;
   assign cmdValid = cmdValid_q;
   assign cmdIndex = cmdIndex_q;
   assign cmdArg   = cmdArg_q;
   assign crcErr   = crcErr_q;
   assign rspBusy  = rspBusy_q;
   assign rspDone  = rspDone_q;

endmodule
